// File: rtl/ota_seq_pkg.sv
// Shared types and default widths for the OTA characterisation sweep sequencer.
package ota_seq_pkg;

  localparam int SETTLE_W = 8;
  localparam int NSAMP_W  = 6;
  localparam int DIV_W    = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    SAMPLE = 3'd2,
    REPORT = 3'd3,
    NEXT   = 3'd4,
    FINISH = 3'd5
  } state_e;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for one asynchronous level input, resets to 0.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Metastability filter chain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/ota_sweep_sequencer.sv
// Steps WavePWM divider settings, settles the OTAs, counts comparator-high samples
// and hands one record per setting to a valid/ready consumer.
module ota_sweep_sequencer #(
  parameter int SETTLE_W = ota_seq_pkg::SETTLE_W,
  parameter int NSAMP_W  = ota_seq_pkg::NSAMP_W,
  parameter int DIV_W    = ota_seq_pkg::DIV_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [SETTLE_W-1:0] cfg_settle,
  input  logic [NSAMP_W-1:0]  cfg_nsamp,
  input  logic [DIV_W-1:0]    cfg_div_first,
  input  logic [DIV_W-1:0]    cfg_div_last,
  input  logic                cmp_a,
  input  logic                cmp_b,
  output logic                ota_oe,
  output logic                dota_oe,
  output logic [DIV_W-1:0]    div_sel,
  output logic                busy,
  output logic                done,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [DIV_W-1:0]    res_div,
  output logic [NSAMP_W:0]    res_cnt_a,
  output logic [NSAMP_W:0]    res_cnt_b
);

  import ota_seq_pkg::*;

  localparam int TMR_W = (SETTLE_W > NSAMP_W) ? SETTLE_W : NSAMP_W;
  localparam int CNT_W = NSAMP_W + 1;

  state_e              state_q, state_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [NSAMP_W-1:0]  nsamp_q, nsamp_d;
  logic [DIV_W-1:0]    last_q, last_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic [CNT_W-1:0]    cnt_a_q, cnt_a_d;
  logic [CNT_W-1:0]    cnt_b_q, cnt_b_d;
  logic                oe_q, oe_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                valid_q, valid_d;
  logic                cmp_a_s, cmp_b_s;

  sync2 u_sync_a (.clk(clk), .rst(rst), .d(cmp_a), .q(cmp_a_s));
  sync2 u_sync_b (.clk(clk), .rst(rst), .d(cmp_b), .q(cmp_b_s));

  // State, latched configuration, counters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      settle_q <= '0;
      nsamp_q  <= '0;
      last_q   <= '0;
      div_q    <= '0;
      tmr_q    <= '0;
      cnt_a_q  <= '0;
      cnt_b_q  <= '0;
      oe_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      nsamp_q  <= nsamp_d;
      last_q   <= last_d;
      div_q    <= div_d;
      tmr_q    <= tmr_d;
      cnt_a_q  <= cnt_a_d;
      cnt_b_q  <= cnt_b_d;
      oe_q     <= oe_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      valid_q  <= valid_d;
    end
  end

  // Next-state sequencing; abort overrides every other transition.
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    nsamp_d  = nsamp_q;
    last_d   = last_q;
    div_d    = div_q;
    tmr_d    = tmr_q;
    cnt_a_d  = cnt_a_q;
    cnt_b_d  = cnt_b_q;

    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            settle_d = cfg_settle;
            nsamp_d  = cfg_nsamp;
            last_d   = cfg_div_last;
            if (cfg_div_first > cfg_div_last) begin
              state_d = FINISH;
            end else begin
              div_d   = cfg_div_first;
              cnt_a_d = '0;
              cnt_b_d = '0;
              tmr_d   = '0;
              state_d = SETTLE;
            end
          end else begin
            state_d = IDLE;
          end
        end
        SETTLE: begin
          if (tmr_q == TMR_W'(settle_q)) begin
            tmr_d   = '0;
            state_d = SAMPLE;
          end else begin
            tmr_d = tmr_q + TMR_W'(1);
          end
        end
        SAMPLE: begin
          // Counts cannot overflow: at most 2^NSAMP_W samples into NSAMP_W+1 bits.
          cnt_a_d = cnt_a_q + CNT_W'(cmp_a_s);
          cnt_b_d = cnt_b_q + CNT_W'(cmp_b_s);
          if (tmr_q == TMR_W'(nsamp_q)) begin
            tmr_d   = '0;
            state_d = REPORT;
          end else begin
            tmr_d = tmr_q + TMR_W'(1);
          end
        end
        REPORT: begin
          if (res_ready) begin
            state_d = NEXT;
          end else begin
            state_d = REPORT;
          end
        end
        NEXT: begin
          if (div_q == last_q) begin
            state_d = FINISH;
          end else begin
            div_d   = div_q + DIV_W'(1);
            cnt_a_d = '0;
            cnt_b_d = '0;
            tmr_d   = '0;
            state_d = SETTLE;
          end
        end
        FINISH: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    // Outputs are registered versions of what the next state implies.
    oe_d    = (state_d == SETTLE) || (state_d == SAMPLE) ||
              (state_d == REPORT) || (state_d == NEXT);
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == FINISH);
    valid_d = (state_d == REPORT);
  end

  assign ota_oe    = oe_q;
  assign dota_oe   = oe_q;
  assign div_sel   = div_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign res_valid = valid_q;
  assign res_div   = div_q;
  assign res_cnt_a = cnt_a_q;
  assign res_cnt_b = cnt_b_q;

endmodule
